// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: per-channel button synchroniser, debouncer, press/release event
//   generator and wrapping mode counter feeding the DDS waveform/step selection.
// Latency: iBtn edge stable at edge k -> level change + event pulse in cycle k+2+DEBOUNCE_CYCLES;
//   mode counter update one cycle after the event. Backpressure: none, pulses are one cycle wide.
//
// Optional feature macro: BTN_LONGPRESS_EN (adds oLongPulse and long-press mode reset).
//
// Ports:
//   CLK           system clock
//   RESET         synchronous active-high reset
//   iBtn          raw buttons, active low, asynchronous to CLK
//   oBtnLevel     debounced level, 1 = pressed
//   oPressPulse   one-cycle pulse on accepted press
//   oReleasePulse one-cycle pulse on accepted release
//   oMode         packed mode counters, channel i at [i*MODE_W +: MODE_W]
//   oModeChg      one-cycle pulse when a channel's mode takes a new value
//   oLongPulse    (BTN_LONGPRESS_EN only) one-cycle pulse when a hold reaches LONG_CYCLES
module btn_mode_ctrl #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int NUM_MODES       = 4,
  parameter int LONG_CYCLES     = 10000000,
  localparam int MODE_W         = $clog2(NUM_MODES)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_BTN-1:0]        iBtn,
  output logic [NUM_BTN-1:0]        oBtnLevel,
  output logic [NUM_BTN-1:0]        oPressPulse,
  output logic [NUM_BTN-1:0]        oReleasePulse,
  output logic [NUM_BTN*MODE_W-1:0] oMode,
  output logic [NUM_BTN-1:0]        oModeChg
`ifdef BTN_LONGPRESS_EN
  ,
  output logic [NUM_BTN-1:0]        oLongPulse
`endif
);

  localparam int MAX_CYC = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
`ifdef BTN_LONGPRESS_EN
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  // 2-FF synchroniser; reset value 1 means "released" on the active-low pins.
  logic [NUM_BTN-1:0] sync1, sync2, s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= iBtn;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                press_d, release_d;
    logic                press_q, release_q, chg_q;
    logic [MODE_W-1:0]   mode_q, mode_next;
`ifdef BTN_LONGPRESS_EN
    logic                long_d, long_q, long_fired_q;
`endif

    // Saturating increment: the counter must never wrap back into a match window.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign mode_next = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_inc;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef BTN_LONGPRESS_EN
      long_d    = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s[i]) state_d = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else begin
`ifdef BTN_LONGPRESS_EN
            // cnt keeps counting the hold; the flag limits this to one shot per hold.
            if (cnt_q == LONG_LAST && !long_fired_q) long_d = 1'b1;
`else
            cnt_d = '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        chg_q     <= 1'b0;
        mode_q    <= '0;
`ifdef BTN_LONGPRESS_EN
        long_q       <= 1'b0;
        long_fired_q <= 1'b0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        chg_q     <= 1'b0;
`ifdef BTN_LONGPRESS_EN
        long_q <= long_d;
        // Flag is cleared at the next accepted press so it survives until the
        // release-driven mode advance has looked at it.
        if (press_d)     long_fired_q <= 1'b0;
        else if (long_d) long_fired_q <= 1'b1;
        if (long_d) begin
          if (mode_q != '0) begin
            mode_q <= '0;
            chg_q  <= 1'b1;
          end
        end else if (release_q && !long_fired_q) begin
          mode_q <= mode_next;
          chg_q  <= 1'b1;
        end
`else
        if (press_q) begin
          mode_q <= mode_next;
          chg_q  <= 1'b1;
        end
`endif
      end
    end

    assign oBtnLevel[i]                 = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign oPressPulse[i]               = press_q;
    assign oReleasePulse[i]             = release_q;
    assign oModeChg[i]                  = chg_q;
    assign oMode[i*MODE_W +: MODE_W]    = mode_q;
`ifdef BTN_LONGPRESS_EN
    assign oLongPulse[i]                = long_q;
`endif
  end

endmodule

// File: tb/tb_btn_mode_ctrl.sv
module tb_btn_mode_ctrl;
  localparam int NB = 2, DEB = 16, NM = 3, LC = 64;
`ifdef BTN_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       CLK, RESET;
  logic [1:0] iBtn;
  logic [1:0] oBtnLevel, oPressPulse, oReleasePulse, oModeChg;
  logic [3:0] oMode;
`ifdef BTN_LONGPRESS_EN
  logic [1:0] oLongPulse;
`endif

  int n_cmp = 0;
  int n_err = 0;

  btn_mode_ctrl #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .NUM_MODES(NM), .LONG_CYCLES(LC)) dut (
    .CLK(CLK), .RESET(RESET), .iBtn(iBtn),
    .oBtnLevel(oBtnLevel), .oPressPulse(oPressPulse), .oReleasePulse(oReleasePulse),
    .oMode(oMode), .oModeChg(oModeChg)
`ifdef BTN_LONGPRESS_EN
    , .oLongPulse(oLongPulse)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: let the rising edge happen, then sit on the falling edge to sample/drive.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    iBtn  = 2'b11;
    RESET = 1'b1;
    cyc(); cyc();
    RESET = 1'b0;
    cyc();
  endtask

  task automatic press_release(input logic [1:0] pins, input int hold, input int rel);
    iBtn = pins;
    repeat (hold) cyc();
    iBtn = 2'b11;
    repeat (rel) cyc();
  endtask

  task automatic test_reset();
    logic [1:0] exp2;
    logic [3:0] expm;
    RESET = 1'b1;
    iBtn  = 2'b00;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_cmp++;
      if ({oBtnLevel, oPressPulse, oReleasePulse, oModeChg, oMode} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d got=%h want=000", c,
                 {oBtnLevel, oPressPulse, oReleasePulse, oModeChg, oMode});
      end
    end
    RESET = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      exp2 = (n == 19) ? 2'b11 : 2'b00;
      n_cmp++;
      if (oPressPulse !== exp2) begin
        n_err++;
        $display("FAIL reset_requal_press n=%0d got=%b want=%b", n, oPressPulse, exp2);
      end
      expm = (!LP && n >= 20) ? 4'b0101 : 4'b0000;
      n_cmp++;
      if (oMode !== expm) begin
        n_err++;
        $display("FAIL reset_requal_mode n=%0d got=%h want=%h", n, oMode, expm);
      end
    end
    iBtn = 2'b11;
    for (int n = 1; n <= 21; n++) begin
      cyc();
      exp2 = (n == 19) ? 2'b11 : 2'b00;
      n_cmp++;
      if (oReleasePulse !== exp2) begin
        n_err++;
        $display("FAIL reset_requal_release n=%0d got=%b want=%b", n, oReleasePulse, exp2);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    iBtn = 2'b10;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (n == 10) iBtn = 2'b11;
      n_cmp++;
      if ({oBtnLevel, oPressPulse, oMode} !== 8'h00) begin
        n_err++;
        $display("FAIL glitch n=%0d got lvl=%b prs=%b mode=%h want all 0", n, oBtnLevel, oPressPulse, oMode);
      end
    end
  endtask

  task automatic test_single_press();
    logic [1:0] ep, el, ec;
    logic [3:0] em;
    do_reset();
    iBtn = 2'b10;
    for (int n = 1; n <= 25; n++) begin
      cyc();
      ep = (n == 19) ? 2'b01 : 2'b00;
      el = (n >= 19) ? 2'b01 : 2'b00;
      em = (!LP && n >= 20) ? 4'b0001 : 4'b0000;
      ec = (!LP && n == 20) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({oPressPulse, oBtnLevel, oModeChg, oMode} !== {ep, el, ec, em}) begin
        n_err++;
        $display("FAIL single_press n=%0d got prs=%b lvl=%b chg=%b mode=%h want prs=%b lvl=%b chg=%b mode=%h",
                 n, oPressPulse, oBtnLevel, oModeChg, oMode, ep, el, ec, em);
      end
    end
    iBtn = 2'b11;
    for (int n = 1; n <= 21; n++) begin
      cyc();
      ep = (n == 19) ? 2'b01 : 2'b00;
      el = (n < 19) ? 2'b01 : 2'b00;
      em = (!LP || n >= 20) ? 4'b0001 : 4'b0000;
      ec = (LP && n == 20) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({oReleasePulse, oBtnLevel, oModeChg, oMode} !== {ep, el, ec, em}) begin
        n_err++;
        $display("FAIL single_release n=%0d got rel=%b lvl=%b chg=%b mode=%h want rel=%b lvl=%b chg=%b mode=%h",
                 n, oReleasePulse, oBtnLevel, oModeChg, oMode, ep, el, ec, em);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [3];
    int chg0, chg1;
    exp_seq = '{2'd1, 2'd2, 2'd0};
    chg0 = 0;
    chg1 = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      iBtn = 2'b10;
      repeat (22) begin
        cyc();
        if (oModeChg[0]) chg0++;
        if (oModeChg[1]) chg1++;
      end
      iBtn = 2'b11;
      repeat (22) begin
        cyc();
        if (oModeChg[0]) chg0++;
        if (oModeChg[1]) chg1++;
      end
      n_cmp++;
      if (oMode !== {2'd0, exp_seq[p]}) begin
        n_err++;
        $display("FAIL wrap_mode press%0d got=%h want=%h", p, oMode, {2'd0, exp_seq[p]});
      end
    end
    n_cmp++;
    if (chg0 != 3 || chg1 != 0) begin
      n_err++;
      $display("FAIL wrap_chg_count got ch0=%0d ch1=%0d want ch0=3 ch1=0", chg0, chg1);
    end
  endtask

  task automatic test_simul_bounce();
    logic [1:0] ep;
    do_reset();
    iBtn = 2'b00;
    for (int n = 1; n <= 36; n++) begin
      cyc();
      if (n == 8)  iBtn[1] = 1'b1;
      if (n == 13) iBtn[1] = 1'b0;
      ep = {n == 32, n == 19};
      n_cmp++;
      if (oPressPulse !== ep) begin
        n_err++;
        $display("FAIL simul_bounce n=%0d got=%b want=%b", n, oPressPulse, ep);
      end
    end
    iBtn = 2'b11;
    repeat (22) cyc();
  endtask

  task automatic test_abort();
    logic [1:0] ep;
    do_reset();
    iBtn = 2'b10;
    repeat (10) cyc();
    RESET = 1'b1;
    cyc();
    n_cmp++;
    if ({oBtnLevel, oPressPulse, oReleasePulse, oModeChg, oMode} !== 12'h000) begin
      n_err++;
      $display("FAIL abort_reset got=%h want=000", {oBtnLevel, oPressPulse, oReleasePulse, oModeChg, oMode});
    end
    RESET = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      ep = (n == 19) ? 2'b01 : 2'b00;
      n_cmp++;
      if (oPressPulse !== ep) begin
        n_err++;
        $display("FAIL abort_requal n=%0d got=%b want=%b", n, oPressPulse, ep);
      end
    end
    iBtn = 2'b11;
    repeat (22) cyc();
  endtask

`ifdef BTN_LONGPRESS_EN
  task automatic test_long();
    logic [1:0] el, ec;
    logic [3:0] em;
    do_reset();
    press_release(2'b10, 22, 22);
    press_release(2'b10, 22, 22);
    n_cmp++;
    if (oMode !== 4'h2) begin
      n_err++;
      $display("FAIL long_premode got=%h want=2", oMode);
    end
    iBtn = 2'b10;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      el = (n == 83) ? 2'b01 : 2'b00;
      ec = (n == 83) ? 2'b01 : 2'b00;
      em = (n >= 83) ? 4'h0 : 4'h2;
      n_cmp++;
      if ({oLongPulse, oModeChg, oMode} !== {el, ec, em}) begin
        n_err++;
        $display("FAIL long_hold n=%0d got lp=%b chg=%b mode=%h want lp=%b chg=%b mode=%h",
                 n, oLongPulse, oModeChg, oMode, el, ec, em);
      end
    end
    iBtn = 2'b11;
    for (int n = 1; n <= 22; n++) begin
      cyc();
      n_cmp++;
      if ({oReleasePulse, oLongPulse, oModeChg, oMode} !== {(n == 19) ? 2'b01 : 2'b00, 2'b00, 2'b00, 4'h0}) begin
        n_err++;
        $display("FAIL long_release n=%0d got rel=%b lp=%b chg=%b mode=%h", n, oReleasePulse, oLongPulse, oModeChg, oMode);
      end
    end
    iBtn = 2'b10;
    repeat (22) cyc();
    n_cmp++;
    if (oMode !== 4'h0) begin
      n_err++;
      $display("FAIL long_short_hold got=%h want=0", oMode);
    end
    iBtn = 2'b11;
    repeat (22) cyc();
    n_cmp++;
    if (oMode !== 4'h1) begin
      n_err++;
      $display("FAIL long_short_release got=%h want=1", oMode);
    end
  endtask
`endif

  initial begin
    RESET = 1'b1;
    iBtn  = 2'b11;
    @(negedge CLK);
    test_reset();
    test_glitch();
    test_single_press();
    test_wrap();
    test_simul_bounce();
    test_abort();
`ifdef BTN_LONGPRESS_EN
    test_long();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
